ahb_master_port: RTL and testbench

AHB_MASTER_PORT -- requirements
Module: ahb_master_port

---
 rtl/ahb_master_port.sv | 182 ++++++++++++++++++
 tb/tb_ahb_master_port.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_master_port.sv
// Single-transfer AHB-Lite master port: takes one local command at a time, checks
// alignment, arbitrates for the bus, runs one NONSEQ transfer and returns a response.
module ahb_master_port (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_REQ, S_ADDR, S_DATA, S_RESP
    } state_t;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_t      state_q, state_d;
    logic        cmd_write_q, cmd_write_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [2:0]  cmd_size_q, cmd_size_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic        err_q, err_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_error_q, rsp_error_d;
    logic        bus_req_q, bus_req_d;
    logic [31:0] haddr_q, haddr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        illegal;

    always_comb begin
        state_d     = state_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_size_d  = cmd_size_q;
        cmd_wdata_d = cmd_wdata_q;
        err_d       = err_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        rsp_rdata_d = 32'h0;

        illegal = (cmd_size_q > 3'd2)
               || (cmd_size_q == 3'd1 && cmd_addr_q[0])
               || (cmd_size_q == 3'd2 && cmd_addr_q[1:0] != 2'b00);

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_write_d = cmd_write;
                    cmd_addr_d  = cmd_addr;
                    cmd_size_d  = cmd_size;
                    cmd_wdata_d = cmd_wdata;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus_grant && HREADY) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                // Grant loss here is ignored: the address phase already started.
                if (HREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (HRESP) begin
                    err_d = 1'b1;
                end
                if (HREADY) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        cmd_ready_d = (state_d == S_IDLE);
        bus_req_d   = (state_d == S_REQ) || (state_d == S_ADDR);
        htrans_d    = (state_d == S_ADDR) ? TRANS_NONSEQ : TRANS_IDLE;
        rsp_valid_d = (state_d == S_RESP);
        rsp_error_d = (state_d == S_RESP) && err_d;

        if (state_q == S_REQ && state_d == S_ADDR) begin
            haddr_d  = cmd_addr_q;
            hwrite_d = cmd_write_q;
            hsize_d  = cmd_size_q;
        end
        if (state_q == S_ADDR && state_d == S_DATA && cmd_write_q) begin
            hwdata_d = cmd_wdata_q;
        end
        if (state_q == S_DATA && state_d == S_RESP && !cmd_write_q && !err_d) begin
            rsp_rdata_d = HRDATA;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= 32'h0;
            cmd_size_q  <= 3'd0;
            cmd_wdata_q <= 32'h0;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
            bus_req_q   <= 1'b0;
            haddr_q     <= 32'h0;
            htrans_q    <= TRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hwdata_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_size_q  <= cmd_size_d;
            cmd_wdata_q <= cmd_wdata_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
            bus_req_q   <= bus_req_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;
    assign bus_req   = bus_req_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_master_port.sv
// Bench for ahb_master_port: directed scenarios with a response scoreboard that
// pairs each accepted command with its expected rsp_rdata/rsp_error.
module tb_ahb_master_port;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;
    logic        bus_req, bus_grant;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ahb_master_port dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .bus_req(bus_req), .bus_grant(bus_grant),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Scoreboard: every response pulse must match the oldest outstanding expectation.
    always @(negedge HCLK) begin
        if (HRESETn === 1'b1 && rsp_valid === 1'b1) begin
            rsp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp got rdata=%h err=%b, required no response", rsp_rdata, rsp_error);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata || rsp_error !== e.err) begin
                    errors++;
                    $display("FAIL rsp_compare got rdata=%h err=%b, required rdata=%h err=%b",
                             rsp_rdata, rsp_error, e.rdata, e.err);
                end else begin
                    $display("rsp rdata=%h err=%b ok", rsp_rdata, rsp_error);
                end
            end
        end
    end

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready_timeout got cmd_ready=%b required 1", cmd_ready);
        end
        cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        $display("cmd w=%b addr=%h size=%0d wdata=%h", w, a, s, d);
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_size = 3'd0; cmd_wdata = 32'h0;
        bus_grant = 1'b0; HRDATA = 32'h0; HREADY = 1'b1; HRESP = 1'b0;
        step();
        step();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_error, bus_req, HTRANS, HWRITE, HSIZE} !== 10'b1000_00_0_000
            || rsp_rdata !== 32'h0 || HADDR !== 32'h0 || HWDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_in_reset got ready=%b rv=%b re=%b req=%b trans=%b addr=%h wr=%b size=%0d wdata=%h rdata=%h, required reset values",
                     cmd_ready, rsp_valid, rsp_error, bus_req, HTRANS, HADDR, HWRITE, HSIZE, HWDATA, rsp_rdata);
        end
        HRESETn = 1'b1;
        step();
        step();
        checks++;
        if (cmd_ready !== 1'b1 || bus_req !== 1'b0 || HTRANS !== 2'b00 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got ready=%b req=%b trans=%b rv=%b required 1 0 00 0",
                     cmd_ready, bus_req, HTRANS, rsp_valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_write();
        int n = 0;
        int nonseq_cnt = 0;
        bus_grant = 1'b1; HREADY = 1'b1; HRESP = 1'b0;
        sb.push_back({32'h0, 1'b0});
        issue(1'b1, 32'h0000_1000, 3'd2, 32'hDEAD_BEEF);
        while (rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
            if (HTRANS === 2'b10) nonseq_cnt++;
            if (n == 2) begin
                checks++;
                if (HTRANS !== 2'b10 || HADDR !== 32'h0000_1000 || HWRITE !== 1'b1 || HSIZE !== 3'd2) begin
                    errors++;
                    $display("FAIL write_addr_phase got trans=%b addr=%h wr=%b size=%0d required 10 00001000 1 2",
                             HTRANS, HADDR, HWRITE, HSIZE);
                end
            end
            if (n == 3) begin
                checks++;
                if (HTRANS !== 2'b00 || HWDATA !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL write_data_phase got trans=%b wdata=%h required 00 deadbeef", HTRANS, HWDATA);
                end
            end
        end
        checks++;
        if (n != 4 || nonseq_cnt != 1) begin
            errors++;
            $display("FAIL write_latency got latency=%0d nonseq_cycles=%0d required 4 1", n, nonseq_cnt);
        end
        step();
        $display("test_write latency=%0d", n);
    endtask

    task automatic test_read_wait();
        int n = 0;
        bus_grant = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h1234_5678;
        sb.push_back({32'h1234_5678, 1'b0});
        issue(1'b0, 32'h0000_0020, 3'd2, 32'h0);
        while (rsp_valid !== 1'b1 && n < 30) begin
            step();
            n++;
            if (n >= 1 && n <= 4) begin
                checks++;
                if (bus_req !== 1'b1) begin
                    errors++;
                    $display("FAIL read_req_held cycle=%0d got bus_req=%b required 1", n, bus_req);
                end
            end
            bus_grant = (n >= 4);
            HREADY = !(n == 6 || n == 7);
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL read_latency got %0d required 9", n);
        end
        bus_grant = 1'b1; HREADY = 1'b1;
        step();
        $display("test_read_wait latency=%0d", n);
    endtask

    task automatic test_misaligned();
        logic        w_tab [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] a_tab [3] = '{32'h0000_0002, 32'h0000_0011, 32'h0000_0000};
        logic [2:0]  s_tab [3] = '{3'd2, 3'd1, 3'd3};
        bus_grant = 1'b1; HREADY = 1'b1; HRDATA = 32'h5555_AAAA;
        for (int i = 0; i < 3; i++) begin
            int  n = 0;
            bit  saw_bus = 0;
            sb.push_back({32'h0, 1'b1});
            issue(w_tab[i], a_tab[i], s_tab[i], 32'h1111_2222);
            if (bus_req !== 1'b0 || HTRANS !== 2'b00) saw_bus = 1;
            while (rsp_valid !== 1'b1 && n < 20) begin
                step();
                n++;
                if (bus_req !== 1'b0 || HTRANS !== 2'b00) saw_bus = 1;
            end
            checks++;
            if (n != 1 || saw_bus) begin
                errors++;
                $display("FAIL misaligned_%0d got latency=%0d bus_activity=%0d required 1 0", i, n, saw_bus);
            end
            step();
            $display("test_misaligned case=%0d latency=%0d", i, n);
        end
    endtask

    task automatic test_error_resp();
        int n = 0;
        bus_grant = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hA5A5_A5A5;
        sb.push_back({32'h0, 1'b1});
        issue(1'b0, 32'h0000_0040, 3'd2, 32'h0);
        while (rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
            if (n == 2) begin
                checks++;
                if (HTRANS !== 2'b10) begin
                    errors++;
                    $display("FAIL err_addr_phase got trans=%b required 10", HTRANS);
                end
                bus_grant = 1'b0;
            end
            if (n == 3) begin
                checks++;
                if (HTRANS !== 2'b00 || bus_req !== 1'b0) begin
                    errors++;
                    $display("FAIL err_grant_loss got trans=%b req=%b required 00 0", HTRANS, bus_req);
                end
                HRESP = 1'b1; HREADY = 1'b0;
            end
            if (n == 4) begin
                HRESP = 1'b1; HREADY = 1'b1;
            end
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL err_latency got %0d required 5", n);
        end
        HRESP = 1'b0; HREADY = 1'b1; bus_grant = 1'b1;
        step();
        $display("test_error_resp latency=%0d", n);
    endtask

    task automatic test_reset_mid();
        bit stray = 0;
        bus_grant = 1'b1; HREADY = 1'b1;
        issue(1'b1, 32'h0000_2000, 3'd2, 32'h0BAD_F00D);
        step();
        step();
        checks++;
        if (HTRANS !== 2'b10 || bus_req !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_in_addr got trans=%b req=%b required 10 1", HTRANS, bus_req);
        end
        #2 HRESETn = 1'b0;
        #1;
        checks++;
        if (HTRANS !== 2'b00 || bus_req !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || HADDR !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async got trans=%b req=%b ready=%b rv=%b addr=%h required 00 0 1 0 0",
                     HTRANS, bus_req, cmd_ready, rsp_valid, HADDR);
        end
        step();
        step();
        HRESETn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) stray = 1;
        end
        checks++;
        if (stray) begin
            errors++;
            $display("FAIL rstmid_after got stray response or not ready, required idle with cmd_ready=1");
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_back_to_back();
        logic        w_tab [3]   = '{1'b1, 1'b0, 1'b1};
        logic [31:0] a_tab [3]   = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0003};
        logic [2:0]  s_tab [3]   = '{3'd2, 3'd2, 3'd1};
        logic [31:0] exp_rd [3]  = '{32'h0, 32'hCAFE_F00D, 32'h0};
        logic        exp_err [3] = '{1'b0, 1'b0, 1'b1};
        int          exp_gap [3] = '{5, 5, 2};
        bus_grant = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hCAFE_F00D;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int gap = 0;
            cmd_write = w_tab[i]; cmd_addr = a_tab[i]; cmd_size = s_tab[i];
            cmd_wdata = 32'h7700_0000 + i;
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_%0d got %b required 1", i, cmd_ready);
            end
            sb.push_back({exp_rd[i], exp_err[i]});
            step();
            while (cmd_ready !== 1'b1 && gap < 20) begin
                step();
                gap++;
            end
            checks++;
            if (gap != exp_gap[i]) begin
                errors++;
                $display("FAIL b2b_busy_%0d got %0d busy cycles required %0d", i, gap, exp_gap[i]);
            end
            $display("b2b cmd=%0d busy=%0d", i, gap);
        end
        cmd_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_misaligned();
        test_error_resp();
        test_reset_mid();
        test_back_to_back();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d outstanding required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
